// File: rtl/receiver_uart.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM and a show-ahead
// receive FIFO with sticky overrun / framing-error flags.
module receiver_uart #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx,
    input  logic                          rd_strb,
    output logic [7:0]                    rd_data,
    output logic                          valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    output logic                          frame_err,
    input  logic                          clr_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [1:0]    r_sync;
    logic          w_rxs;
    logic [2:0]    r_state;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_push;
    logic [7:0]    r_push_data;
    logic          w_stop_bad;

    // Reset to idle-high so a reset never looks like a start edge by itself.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_sync <= 2'b11;
        else         r_sync <= {r_sync[0], rx};
    end

    assign w_rxs      = r_sync[1];
    assign w_stop_bad = (r_state == S_STOP) && (r_clk_cnt == LAST_CNT) && !w_rxs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_clk_cnt == HALF_CNT) begin
                        if (!w_rxs) begin
                            r_clk_cnt <= '0;
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) r_state <= S_STOP;
                        else                   r_bit_idx <= r_bit_idx + 3'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_clk_cnt == LAST_CNT) begin
                        r_clk_cnt <= '0;
                        if (w_rxs) begin
                            r_push      <= 1'b1;
                            r_push_data <= r_shift;
                            r_state     <= S_IDLE;
                        end else begin
                            r_state <= S_BREAK;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (w_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_ok;
    logic        w_overrun_set;

    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop         = rd_strb && !w_empty;
    // A pop on a full FIFO frees the head slot in time for the same-edge push.
    assign w_push_ok     = r_push && (!w_full || w_pop);
    assign w_overrun_set = r_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (w_overrun_set) overrun <= 1'b1;
            else if (clr_err)  overrun <= 1'b0;
            if (w_stop_bad)    frame_err <= 1'b1;
            else if (clr_err)  frame_err <= 1'b0;
        end
    end

    assign valid   = !w_empty;
    assign count   = r_wr_ptr - r_rd_ptr;
    assign rd_data = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_receiver_uart.sv
// Bench for receiver_uart at 16 clocks/bit with a 4-entry FIFO: frame table,
// scoreboard of expected bytes, and hand sequences for break, glitch, reset, wrap.
module tb_receiver_uart;

  localparam int CPB = 16;

  logic       clk;
  logic       resetn;
  logic       rx;
  logic       rd_strb;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       valid;
  logic [2:0] count;
  logic       overrun;
  logic       frame_err;

  receiver_uart #(
    .CLK_FREQ_HZ(16),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (rx),
    .rd_strb  (rd_strb),
    .rd_data  (rd_data),
    .valid    (valid),
    .count    (count),
    .overrun  (overrun),
    .frame_err(frame_err),
    .clr_err  (clr_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic bit_wait();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_wait();
    end
    rx = stop_ok;
    bit_wait();
    rx = 1'b1;
    if (!stop_ok) bit_wait();
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_valid"}, 32'(valid), 32'd1);
      check({name, "_data"}, 32'(rd_data), 32'(e));
    end
    rd_strb = 1'b1;
    @(negedge clk);
    rd_strb = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  // stimulus table
  typedef struct packed {
    logic [7:0] data;
    logic       stop_ok;
    logic       accept;
    logic [2:0] exp_count;
    logic       exp_overrun;
    logic       exp_frame_err;
  } vec_t;

  vec_t vecs[8];

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok);
      if (vecs[i].accept) exp_q.push_back(vecs[i].data);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_overrun));
      check($sformatf("vec%0d_frame_err", i), 32'(frame_err), 32'(vecs[i].exp_frame_err));
    end
  endtask

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0};
    vecs[3] = '{8'h02, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[4] = '{8'h03, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
    vecs[5] = '{8'h04, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0};
    vecs[6] = '{8'h05, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
    vecs[7] = '{8'h3C, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};

    resetn  = 1'b0;
    rx      = 1'b1;
    rd_strb = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);

    // single bytes
    apply_vecs(0, 1);
    pop_check("single0");
    check("single_count_after_pop", 32'(count), 32'd1);
    pop_check("single1");
    check("single_empty_valid", 32'(valid), 32'd0);
    check("single_empty_data", 32'(rd_data), 32'h00);
    check("single_empty_count", 32'(count), 32'd0);

    // fill and overrun
    apply_vecs(2, 6);
    for (int i = 0; i < 4; i++) pop_check($sformatf("fill%0d", i));
    check("fill_drained_valid", 32'(valid), 32'd0);
    rd_strb = 1'b1;
    @(negedge clk);
    rd_strb = 1'b0;
    check("pop_empty_count", 32'(count), 32'd0);
    pulse_clr();
    check("fill_clr_overrun", 32'(overrun), 32'd0);

    // simultaneous push and pop when full
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h31 + 8'(i), 1'b1);
      exp_q.push_back(8'h31 + 8'(i));
    end
    check("full_count", 32'(count), 32'd4);
    fork
      send_frame(8'h35, 1'b1);
      begin
        // stop sample lands on the 155th rising edge, push on the 156th
        repeat (155) @(negedge clk);
        check("pp_valid", 32'(valid), 32'd1);
        check("pp_head", 32'(rd_data), 32'(exp_q.pop_front()));
        exp_q.push_back(8'h35);
        rd_strb = 1'b1;
        @(negedge clk);
        rd_strb = 1'b0;
      end
    join
    check("pp_count", 32'(count), 32'd4);
    check("pp_overrun", 32'(overrun), 32'd0);
    for (int i = 0; i < 4; i++) pop_check($sformatf("pp_drain%0d", i));
    check("pp_drained_valid", 32'(valid), 32'd0);

    // framing error
    apply_vecs(7, 7);
    pulse_clr();
    check("fe_clr", 32'(frame_err), 32'd0);

    // break: one error event, then a clean byte
    rx = 1'b0;
    repeat (10) bit_wait();
    check("brk_frame_err", 32'(frame_err), 32'd1);
    pulse_clr();
    repeat (30) bit_wait();
    check("brk_single_event", 32'(frame_err), 32'd0);
    check("brk_no_bytes", 32'(count), 32'd0);
    rx = 1'b1;
    bit_wait();
    send_frame(8'h7E, 1'b1);
    exp_q.push_back(8'h7E);
    check("brk_after_count", 32'(count), 32'd1);
    check("brk_after_fe", 32'(frame_err), 32'd0);
    pop_check("brk_after");

    // glitch on idle line
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_valid", 32'(valid), 32'd0);
    check("glitch_frame_err", 32'(frame_err), 32'd0);
    check("glitch_overrun", 32'(overrun), 32'd0);

    // reset mid-frame with a held byte and a set error flag
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b0);
    check("prerst_count", 32'(count), 32'd1);
    check("prerst_fe", 32'(frame_err), 32'd1);
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 4; i++) begin
      rx = logic'((8'hC9 >> i) & 8'h01);
      bit_wait();
    end
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_rd_data", 32'(rd_data), 32'h00);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rx = 1'b1;
    resetn = 1'b1;
    exp_q.delete();
    repeat (2) bit_wait();
    check("postrst_idle_count", 32'(count), 32'd0);
    send_frame(8'hC9, 1'b1);
    exp_q.push_back(8'hC9);
    check("postrst_count", 32'(count), 32'd1);
    pop_check("postrst");

    // pointer wrap
    for (int i = 0; i < 10; i++) begin
      send_frame(8'h10 + 8'(i), 1'b1);
      exp_q.push_back(8'h10 + 8'(i));
      pop_check($sformatf("wrap%0d", i));
    end
    check("wrap_overrun", 32'(overrun), 32'd0);
    check("wrap_empty", 32'(valid), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/receiver_uart.md
# receiver_uart

Serial 8N1 UART receiver with a small show-ahead receive FIFO. It is the receive-side counterpart of the UART emitter used by the RISC-V SoC. It de-serialises the `rx` pin into bytes and queues them. It exposes the bytes through a read-strobe pop interface that the processor's memory-mapped IO page drives as a readable data word plus status bits.

## Interface
Parameters:
- `CLK_FREQ_HZ`, default 12_000_000: system clock frequency.
- `BAUD_RATE`, default 115_200: serial bit rate. `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE`, integer truncation; must be ≥ 4.
- `FIFO_DEPTH`, default 16: receive FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk`, input, 1: single system clock; all logic is on its rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: serial line, asynchronous to `clk`, idle high.
- `rd_strb`, input, 1: pop the head byte this cycle; ignored when `valid`=0.
- `rd_data`, output, 8: head byte, show-ahead; 8'h00 when FIFO empty.
- `valid`, output, 1: FIFO not empty.
- `count`, output, $clog2(FIFO_DEPTH)+1: number of bytes held.
- `overrun`, output, 1: sticky; a byte arrived while the FIFO was full.
- `frame_err`, output, 1: sticky; stop bit sampled low.
- `clr_err`, input, 1: clears `overrun` and `frame_err`.

## Operation
- `rx` passes through a 2-FF synchroniser, reset to 1; the FSM sees only the synchronised value `rxs`.
- Bit counter: 0..CLKS_PER_BIT-1. Bit index: 0..7.
- FSM states:
  - IDLE: on `rxs`=0, clear the counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles (mid start bit), then sample. If `rxs`=0, clear the counter and bit index and go to DATA. If `rxs`=1, treat as a glitch and return to IDLE, with no flag set.
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample.
    - `rxs`=1: issue a push request for the assembled byte and return to IDLE.
    - `rxs`=0: set `frame_err`, discard the byte, go to BREAK.
  - BREAK: stay until `rxs`=1, then go to IDLE. A held-low line (break condition) yields exactly one `frame_err` event and no bytes.
- FIFO: circular buffer with write and read pointers of $clog2(FIFO_DEPTH)+1 bits. Full/empty are derived from pointer MSB comparison. Pointers wrap modulo 2·FIFO_DEPTH.
- Push when not full: write the byte and increment `count`.
- Push when full and no pop in the same cycle: drop the byte, set `overrun`, leave FIFO contents unchanged.
- Push and pop in the same cycle:
  - Full: the pop frees a slot, the push succeeds, no `overrun`, `count` unchanged.
  - Empty: the pop is ignored and the push succeeds.
- `rd_strb` when empty has no effect.
- `clr_err` and a new error event in the same cycle: the flag ends set (set wins).
- The receiver never stalls. The FIFO state never affects FSM timing.

## Timing
- Reset values (asynchronous): FSM=IDLE, synchroniser=2'b11, pointers=0, `count`=0, `valid`=0, `rd_data`=8'h00, `overrun`=0, `frame_err`=0.
- Reset asserted mid-frame: the partial byte is lost. After release, the receiver waits in IDLE for the next falling edge. If `rx` is still low, it resyncs only after a high→low transition is seen.
- `rx` to `rxs`: 2 cycles.
- Sample points:
  - Start bit: CLKS_PER_BIT/2 cycles after the falling edge is detected.
  - Each later bit: spaced exactly CLKS_PER_BIT cycles after the previous sample.
  - Stop bit: sampled 9·CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after edge detect.
- Stop-bit sample to push: the push is registered; `valid`/`count`/`rd_data` update on the next edge (1 cycle).
- Pop: `rd_strb` high at edge N. Then `rd_data`/`count`/`valid` reflect the new head after edge N. The popped byte was visible on `rd_data` before edge N.
- Error flags: set on the edge that samples the bad stop bit or drops the byte. Cleared on the edge where `clr_err`=1.
- Back-to-back frames with a stop bit of exactly one bit period are received without loss.

## Test plan
CLK_FREQ_HZ=16, BAUD_RATE=1 (16 clocks/bit), FIFO_DEPTH=4.
- Single byte: drive 0x55, then 0xA3 8N1 on `rx`. Required: `valid` goes 1 and `rd_data`=0x55, `count`=1, a few cycles after the stop midpoint. Pop gives `rd_data`=0xA3 with `count`=1, then after the final pop `valid`=0 and `rd_data`=0x00.
- Fill/overrun: send 5 bytes 0x01..0x05 with no pops. Required: `count`=4 and `overrun`=1. Popping yields 0x01, 0x02, 0x03, 0x04, then `valid`=0. `clr_err` clears `overrun`.
- Simultaneous push and pop when full: with 4 bytes held, assert `rd_strb` on the same edge as the 5th byte's push. Required: `count` stays 4, `overrun`=0, and the new tail is the 5th byte.
- Framing error and break:
  - Send 0x3C with a low stop bit. Required: `frame_err`=1 and no push.
  - Hold `rx` low for 40 bit periods, then release and send 0x7E. Required: a single error event and 0x7E received correctly.
- Glitch and reset: a 3-cycle low pulse on idle `rx` yields no byte and no flags. Assert `resetn`=0 for 2 cycles mid-frame during bit 4. Required: all outputs return to reset values immediately; the next full frame of 0xC9 is received correctly.
- Pointer wrap: 10 sequential bytes 0x10..0x19, each popped within one frame time. Required: all bytes are read in order with `overrun`=0.
